// File: rtl/id_stage.sv
// Instruction-decode stage: one-entry skid buffer in front of registered decode
// outputs, with a one-cycle bubble inserted on load-use hazards.
module id_stage #(
  parameter int                  INST_W   = 16,
  parameter int                  OPCODE_W = 5,
  parameter int                  REG_N    = 4,
  parameter logic [OPCODE_W-1:0] NOP_OP   = 5'h00
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_valid,
  input  logic [INST_W-1:0]   if_inst,
  output logic                if_ready,
  input  logic                stall_ex,
  input  logic                flush,
  output logic                id_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_N-1:0]    nREGA,
  output logic [REG_N-1:0]    nREGB,
  output logic [7:0]          imm,
  output logic                load_use
);

  localparam int OP_LSB = INST_W - OPCODE_W;
  localparam int A_LSB  = OP_LSB - REG_N;
  localparam int B_LSB  = A_LSB - REG_N;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'h01);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(5'h02);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5'h03);
  localparam logic [OPCODE_W-1:0] OP_ORR  = OPCODE_W'(5'h04);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(5'h05);
  localparam logic [OPCODE_W-1:0] OP_STR  = OPCODE_W'(5'h06);
  localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(5'h07);
  localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(5'h08);
  localparam logic [OPCODE_W-1:0] OP_LDR  = OPCODE_W'(5'h09);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(5'h0A);
  localparam logic [OPCODE_W-1:0] OP_BLX  = OPCODE_W'(5'h0B);
  localparam logic [OPCODE_W-1:0] OP_PUSH = OPCODE_W'(5'h0C);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'h0D);
  localparam logic [OPCODE_W-1:0] OP_LSR  = OPCODE_W'(5'h0E);
  localparam logic [OPCODE_W-1:0] OP_LSL  = OPCODE_W'(5'h0F);
  localparam logic [OPCODE_W-1:0] OP_ASR  = OPCODE_W'(5'h10);
  localparam logic [OPCODE_W-1:0] OP_POP  = OPCODE_W'(5'h11);
  localparam logic [OPCODE_W-1:0] OP_LDRL = OPCODE_W'(5'h12);
  localparam logic [OPCODE_W-1:0] OP_LDRH = OPCODE_W'(5'h13);

  typedef enum logic {EMPTY, FULL} skid_state_e;

  function automatic logic uses_a(input logic [OPCODE_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_MUL, OP_AND, OP_ORR, OP_XOR, OP_STR, OP_CMP,
      OP_NOT, OP_BLX, OP_PUSH, OP_ADDI, OP_LSR, OP_LSL, OP_ASR: r = 1'b1;
      default:                                                   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_b(input logic [OPCODE_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_MUL, OP_AND, OP_ORR, OP_XOR, OP_STR, OP_CMP,
      OP_MOV, OP_LDR: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_load(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDR) || (op == OP_POP) || (op == OP_LDRL) || (op == OP_LDRH);
  endfunction

  skid_state_e         state_q;
  logic [INST_W-1:0]   skid_q;
  logic                id_valid_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic [REG_N-1:0]    nrega_q;
  logic [REG_N-1:0]    nregb_q;
  logic [7:0]          imm_q;
  logic                load_use_q;

  logic                accept;
  logic                cand_present;
  logic [INST_W-1:0]   cand_inst;
  logic [OPCODE_W-1:0] cand_op;
  logic [REG_N-1:0]    cand_a;
  logic [REG_N-1:0]    cand_b;
  logic                hazard;

  // NOTE: every always_comb output is assigned on every path (no defaults
  // missing), so no latch can be inferred.
  always_comb begin
    accept       = if_valid && (state_q == EMPTY);
    cand_present = (state_q == FULL) || accept;
    cand_inst    = (state_q == FULL) ? skid_q : if_inst;
    cand_op      = cand_inst[INST_W-1:OP_LSB];
    cand_a       = cand_inst[OP_LSB-1:A_LSB];
    cand_b       = cand_inst[A_LSB-1:B_LSB];
    // The output slot holds the load; its destination is nREGA.
    hazard       = cand_present && id_valid_q && is_load(opcode_q) &&
                   ((uses_a(cand_op) && (cand_a == nrega_q)) ||
                    (uses_b(cand_op) && (cand_b == nrega_q)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      skid_q     <= '0;
      id_valid_q <= 1'b0;
      opcode_q   <= NOP_OP;
      nrega_q    <= '0;
      nregb_q    <= '0;
      imm_q      <= '0;
      load_use_q <= 1'b0;
    end else if (flush) begin
      state_q    <= EMPTY;
      id_valid_q <= 1'b0;
      opcode_q   <= NOP_OP;
      nrega_q    <= '0;
      nregb_q    <= '0;
      imm_q      <= '0;
      load_use_q <= 1'b0;
    end else if (stall_ex) begin
      if (accept) begin
        state_q <= FULL;
        skid_q  <= if_inst;
      end
    end else if (hazard) begin
      if (accept) begin
        state_q <= FULL;
        skid_q  <= if_inst;
      end
      id_valid_q <= 1'b0;
      opcode_q   <= NOP_OP;
      nrega_q    <= '0;
      nregb_q    <= '0;
      imm_q      <= '0;
      load_use_q <= 1'b1;
    end else if (cand_present) begin
      state_q    <= EMPTY;
      id_valid_q <= 1'b1;
      opcode_q   <= cand_op;
      nrega_q    <= cand_a;
      nregb_q    <= cand_b;
      imm_q      <= cand_inst[7:0];
      load_use_q <= 1'b0;
    end else begin
      id_valid_q <= 1'b0;
      opcode_q   <= NOP_OP;
      nrega_q    <= '0;
      nregb_q    <= '0;
      imm_q      <= '0;
      load_use_q <= 1'b0;
    end
  end

  assign if_ready = (state_q == EMPTY);
  assign id_valid = id_valid_q;
  assign opcode   = opcode_q;
  assign nREGA    = nrega_q;
  assign nREGB    = nregb_q;
  assign imm      = imm_q;
  assign load_use = load_use_q;

endmodule
